// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 codes for loads and stores
//   - FSM state encoding (also driven out on the debug state port)
//   - access_err(): width/alignment/funct3 legality of a request
package lsu_pkg;

  // Load widths (req_we = 0)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store widths (req_we = 1)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Returns 1 for an illegal funct3 or a misaligned halfword/word access.
  // The address range check depends on the memory depth and lives in the top.
  function automatic logic access_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] byte_off);
    logic bad_f3;
    logic misaligned;
    if (we) begin
      bad_f3 = (funct3 > F3_SW);
    end else begin
      bad_f3 = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    // funct3[1:0] encodes the width for both loads and stores
    misaligned = ((funct3[1:0] == 2'b01) && byte_off[0]) ||
                 ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed byte/halfword out of a
// memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   word     in  32  word read from memory
//   byte_off in  2   byte offset within the word (addr[1:0])
//   funct3   in  3   load width/sign code (LB/LH/LW/LBU/LHU)
//   data     out 32  extended load result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    case (byte_off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  end

  // Halfwords are only legal at even offsets, so byte_off[1] alone picks the lane
  assign sel_half = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = 32'h0;
    case (funct3)
      F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   data = word;
      F3_LBU:  data = {24'h0, sel_byte};
      F3_LHU:  data = {16'h0, sel_half};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed data memory with
// combinational read. One request in flight at a time.
//
// Handshake (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. req_ready is 1 only in IDLE; rsp_valid is 1
// only in RESP, and rsp_rdata/rsp_err stay stable until rsp_ready is seen.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32I width/sign code
//   req_addr               byte address
//   req_wdata              right-aligned store data
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              extended load data, 0 for stores and errors
//   rsp_err                misaligned / illegal funct3 / out of range
//   mem_write              memory write strobe
//   mem_addr               word-aligned byte address (0 outside ACCESS/WRITE)
//   mem_wdata              full word to write
//   mem_rdata              memory read data for mem_addr
//   state_dbg              current FSM state
//
// Flow: IDLE -> ACCESS -> RESP for loads and SW, IDLE -> ACCESS -> WRITE ->
// RESP for SB/SH (read-modify-write), IDLE -> RESP for rejected requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  state_dbg
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

  lsu_state_e state, state_nxt;

  // Request captured at accept; the core is free to change its inputs after
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        req_err;
  logic        is_sub_store;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [31:0] word_addr;

  assign accept  = req_valid && (state == ST_IDLE);
  assign req_err = access_err(req_we, req_funct3, req_addr[1:0]) ||
                   ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);

  // Byte and halfword stores need a read-modify-write through WRITE
  assign is_sub_store = we_q && (funct3_q != F3_SW);
  assign word_addr    = {addr_q[31:2], 2'b00};

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: state_nxt = is_sub_store ? ST_WRITE : ST_RESP;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. mem_write is purely a decode of state, so the
  // asynchronous reset of the state register drops it immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        mem_addr = word_addr;
        if (we_q && (funct3_q == F3_SW)) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
        end
      end
      ST_WRITE: begin
        mem_addr  = word_addr;
        mem_write = 1'b1;
        mem_wdata = merged_q;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  load_align u_load_align (
    .word     (mem_rdata),
    .byte_off (addr_q[1:0]),
    .funct3   (funct3_q),
    .data     (load_data)
  );

  // Insert the store byte/halfword into its lane of the current word
  always_comb begin
    merged = mem_rdata;
    if (funct3_q == F3_SB) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      merged_q    <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q        <= req_we;
        funct3_q    <= req_funct3;
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        // Cleared here so stores and errors answer with 0
        rsp_rdata_q <= 32'h0;
        rsp_err_q   <= req_err;
      end else if (state == ST_ACCESS) begin
        if (!we_q) begin
          rsp_rdata_q <= load_data;
        end else if (is_sub_store) begin
          merged_q <= merged;
        end
      end
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  lsu_state_e  state_dbg;

  load_store_unit #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  int          wr_count = 0;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bd_write(input logic [9:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Issues one request (called at posedge+1 with the unit idle), waits for
  // the response, optionally holds rsp_ready low for bp cycles, retires it.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int bp, output int lat,
                        output logic [31:0] rdata, output logic err);
    int wr0;
    rsp_ready  = (bp == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    // Scramble the request inputs: the unit must have latched them
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) check({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    if (bp > 0) begin
      wr0 = wr_count;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        check({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_bp_rdata"}, rsp_rdata, rdata);
        check({tag, "_bp_err"}, 32'(rsp_err), 32'(err));
        check({tag, "_bp_req_ready"}, 32'(req_ready), 32'd0);
      end
      check({tag, "_bp_no_mem"}, 32'(wr_count), 32'(wr0));
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_retired"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_writes);
    int lat;
    int wr0;
    logic [31:0] rd;
    logic er;
    wr0 = wr_count;
    exp_q.push_back(exp_rdata);
    do_req(tag, we, f3, addr, wdata, bp, lat, rd, er);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, 32'(er), 32'(exp_err));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_writes"}, 32'(wr_count - wr0), 32'(exp_writes));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    reset_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    reset_n = 1'b1;

    bd_write(10'h040, 32'h8899AABB);
    bd_write(10'h3FF, 32'hCAFEF00D);

    //   tag         we    f3      addr          wdata          bp  rdata          err  lat wr
    run("lb_103",    1'b0, F3_LB,  32'h0000_0103, 32'h0,         0, 32'hFFFFFF88, 1'b0, 2, 0);
    run("lhu_102",   1'b0, F3_LHU, 32'h0000_0102, 32'h0,         0, 32'h00008899, 1'b0, 2, 0);
    run("lh_100",    1'b0, F3_LH,  32'h0000_0100, 32'h0,         0, 32'hFFFFAABB, 1'b0, 2, 0);
    run("lbu_100",   1'b0, F3_LBU, 32'h0000_0100, 32'h0,         0, 32'h000000BB, 1'b0, 2, 0);
    run("sb_101",    1'b1, F3_SB,  32'h0000_0101, 32'hFFFFFF5A,  0, 32'h0,        1'b0, 3, 1);
    check("sb_101_mem", mem[10'h040], 32'h88995ABB);
    run("sh_102",    1'b1, F3_SH,  32'h0000_0102, 32'hABCD1234,  0, 32'h0,        1'b0, 3, 1);
    check("sh_102_mem", mem[10'h040], 32'h12345ABB);
    run("sw_104",    1'b1, F3_SW,  32'h0000_0104, 32'hDEADBEEF,  0, 32'h0,        1'b0, 2, 1);
    check("sw_104_mem", mem[10'h041], 32'hDEADBEEF);
    run("lw_104_bp", 1'b0, F3_LW,  32'h0000_0104, 32'h0,         5, 32'hDEADBEEF, 1'b0, 2, 0);
    run("lw_102",    1'b0, F3_LW,  32'h0000_0102, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("sh_001",    1'b1, F3_SH,  32'h0000_0001, 32'h1111,      0, 32'h0,        1'b1, 1, 0);
    run("lh_101",    1'b0, F3_LH,  32'h0000_0101, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("lw_oor",    1'b0, F3_LW,  32'h0000_1000, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("sw_oor",    1'b1, F3_SW,  32'h8000_0000, 32'h5555,      0, 32'h0,        1'b1, 1, 0);
    run("lw_last",   1'b0, F3_LW,  32'h0000_0FFC, 32'h0,         0, 32'hCAFEF00D, 1'b0, 2, 0);
    run("ld_f3_3",   1'b0, 3'd3,   32'h0000_0100, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("ld_f3_6",   1'b0, 3'd6,   32'h0000_0100, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("st_f3_3",   1'b1, 3'd3,   32'h0000_0100, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    run("st_f3_4",   1'b1, 3'd4,   32'h0000_0100, 32'h0,         0, 32'h0,        1'b1, 1, 0);
    check("err_mem_intact", mem[10'h040], 32'h12345ABB);

    // Reset in the middle of an SB read-modify-write
    wr0 = wr_count;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SB;
    req_addr = 32'h0000_0100; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_write_state", 32'(state_dbg), 32'(ST_WRITE));
    check("rst_in_write_strobe", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mem_write_drop", 32'(mem_write), 32'd0);
    check("rst_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_write_aborted", 32'(wr_count - wr0), 32'd0);
    check("rst_mem_intact", mem[10'h040], 32'h12345ABB);
    run("lb_after_rst", 1'b0, F3_LB, 32'h0000_0103, 32'h0, 0, 32'h00000012, 1'b0, 2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, data memory depth in 32-bit words; used only for the out-of-range check.
REQ-002 Port: clk  in  1  clock, all state updates on rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  in  1  core presents a load/store request.
REQ-005 Port: req_ready  out  1  unit accepts a request this cycle.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data, right-aligned.
REQ-010 Port: rsp_valid  out  1  response available.
REQ-011 Port: rsp_ready  in  1  core consumes the response.
REQ-012 Port: rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 Port: rsp_err  out  1  misaligned, illegal funct3 or out-of-range access.
REQ-014 Port: mem_write  out  1  write strobe to the word-addressed data memory.
REQ-015 Port: mem_addr  out  32  byte address to memory, bits [1:0] always 0.
REQ-016 Port: mem_wdata  out  32  full word to write.
REQ-017 Port: mem_rdata  in  32  word at mem_addr, combinational read.

Function
REQ-018 FSM states: IDLE, ACCESS, WRITE, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-019 Accept on req_valid & req_ready; latch we, funct3, addr and wdata; the core may change its inputs afterwards.
REQ-020 Error check at accept: halfword with addr[0]=1, word with addr[1:0]!=0, load funct3 in {3,6,7}, store funct3 >= 3, or addr[31:2] >= DEPTH_WORDS; an error goes IDLE->RESP with rsp_err=1, rsp_rdata=0 and no memory access.
REQ-021 Otherwise IDLE->ACCESS; mem_addr = {addr[31:2],2'b00} in ACCESS and WRITE, otherwise 0.
REQ-022 Load in ACCESS: select byte/halfword by addr[1:0]; sign-extend LB/LH, zero-extend LBU/LHU; register into rsp_rdata; ACCESS->RESP.
REQ-023 SW in ACCESS: mem_write=1, mem_wdata=latched wdata; ACCESS->RESP.
REQ-024 SB/SH in ACCESS: read mem_rdata, merge wdata[7:0]/[15:0] into lane addr[1:0], register the merged word; ACCESS->WRITE.
REQ-025 WRITE: mem_write=1, mem_wdata=merged word; WRITE->RESP.
REQ-026 mem_write SHALL be 0 in IDLE and RESP, and whenever reset_n is low.
REQ-027 RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1; then RESP->IDLE. A new request is accepted no earlier than the cycle after RESP.
REQ-028 Latency from accept edge to rsp_valid: load/SW 2 cycles; SB/SH 3 cycles; error 1 cycle.
REQ-029 Back-pressure: rsp_ready low for N cycles adds exactly N cycles; no memory activity occurs while waiting.

Reset
REQ-030 Reset asserted: state=IDLE, rsp_rdata=0, rsp_err=0, all latched request registers 0, mem_write=0 at once (asynchronous).
REQ-031 Reset during WRITE aborts the write; memory contents are determined by the memory's own reset.

Structure
REQ-032 Package lsu_pkg: funct3 constants (LB..LHU, SB..SW) and the state enum type.
REQ-033 Sub-module load_align: combinational lane select and sign/zero extension; the merge logic stays inline.

Verification
REQ-034 Word 0x100 = 0x8899AABB, LB at 0x103 -> rsp_rdata=0xFFFFFF88, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-035 Same word, LHU at 0x102 -> 0x00008899; LH at 0x100 -> 0xFFFFAABB.
REQ-036 SB 0x5A at 0x101 -> mem_write exactly once, in WRITE; word becomes 0x88995ABB; rsp_valid 3 cycles after accept.
REQ-037 LW at 0x102 and SH at 0x001 -> rsp_err=1, rsp_rdata=0, mem_write never asserted.
REQ-038 LW with rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready=0 throughout, response retires on the 6th cycle.
REQ-039 reset_n pulsed low during WRITE of an SB -> mem_write drops immediately, state=IDLE, req_ready=1 after release.
